// File: rtl/nabp_image_accumulator_pkg.sv
// nabp_image_accumulator_pkg: shared widths and FSM encoding for the image accumulator
package nabp_image_accumulator_pkg;
    localparam int kDataLength = 8;
    localparam int kCacheDataLength = 32;
    localparam int kImageAddressLength = 10;
    localparam int DATA_W = kDataLength;
    localparam int LANES = kCacheDataLength / kDataLength;
    localparam int ADDR_W = kImageAddressLength;
    localparam int ACC_W = 16;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READY} state_t;
endpackage

// File: rtl/nabp_image_accumulator_if.sv
// nabp_image_accumulator_if: packed pixel stream from the NABP core with its ready throttle
interface nabp_image_accumulator_if #(
    parameter int DATA_W = nabp_image_accumulator_pkg::DATA_W,
    parameter int LANES = nabp_image_accumulator_pkg::LANES,
    parameter int ADDR_W = nabp_image_accumulator_pkg::ADDR_W
) ();
    logic ir_kick;
    logic ir_wr_en;
    logic [ADDR_W-1:0] ir_addr;
    logic [LANES*DATA_W-1:0] ir_val;
    logic ir_done;
    logic ir_enable;
    modport master (output ir_kick, ir_wr_en, ir_addr, ir_val, ir_done, input ir_enable);
    modport slave (input ir_kick, ir_wr_en, ir_addr, ir_val, ir_done, output ir_enable);
endinterface

// File: rtl/nabp_lane_adder.sv
// nabp_lane_adder: one accumulator lane; wraps by default, clamps under NABP_ACC_SATURATE_EN
module nabp_lane_adder #(
    parameter int DATA_W = 8,
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] val,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full;
    always_comb begin
        full = {1'b0, acc} + (ACC_W+1)'(val);
`ifdef NABP_ACC_SATURATE_EN
        sum = full[ACC_W] ? '1 : full[ACC_W-1:0];
`else
        sum = full[ACC_W-1:0];
`endif
        carry = full[ACC_W];
    end
endmodule

// File: rtl/nabp_image_accumulator.sv
// nabp_image_accumulator: read-modify-write image accumulation behind the NABP core.
// Lane arithmetic saturates when NABP_ACC_SATURATE_EN is defined, otherwise wraps.
module nabp_image_accumulator #(
    parameter int DATA_W = nabp_image_accumulator_pkg::DATA_W,
    parameter int LANES = nabp_image_accumulator_pkg::LANES,
    parameter int ADDR_W = nabp_image_accumulator_pkg::ADDR_W,
    parameter int ACC_W = nabp_image_accumulator_pkg::ACC_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nabp_image_accumulator_if.slave ir,
    output logic                   frame_ready,
    output logic                   overflow,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [LANES*ACC_W-1:0] rd_data
);
    import nabp_image_accumulator_pkg::*;
    localparam int VW = LANES * DATA_W;
    localparam int MW = LANES * ACC_W;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
    logic [VW-1:0] s1_val_q, s1_val_d, s2_val_q, s2_val_d;
    logic [MW-1:0] s1_rd_q, s1_rd_d, s2_old_q, s2_old_d, rd_data_q, rd_data_d;
    logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, overflow_q, overflow_d;
    logic [MW-1:0] mem [2**ADDR_W];
    logic [MW-1:0] sum, wdata, rword;
    logic [LANES-1:0] carry;
    logic [ADDR_W-1:0] raddr, waddr;
    logic we, accept, start;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        nabp_lane_adder #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_add (
            .acc(s2_old_q[i*ACC_W +: ACC_W]),
            .val(s2_val_q[i*DATA_W +: DATA_W]),
            .sum(sum[i*ACC_W +: ACC_W]),
            .carry(carry[i])
        );
    end

    always_comb begin
        accept = state_q == ACCUM && ir.ir_wr_en;
        start = (state_q == IDLE || state_q == READY) && ir.ir_kick;
        we = state_q == CLEAR || s2_v_q;
        waddr = state_q == CLEAR ? cnt_q : s2_addr_q;
        wdata = state_q == CLEAR ? '0 : sum;
        raddr = state_q == READY ? rd_addr : ir.ir_addr;
        // write-first read covers the beat two ahead, whose sum lands this very edge
        rword = we && waddr == raddr ? wdata : mem[raddr];
        state_d = start ? CLEAR :
                  state_q == CLEAR && cnt_q == '1 ? ACCUM :
                  state_q == ACCUM && ir.ir_done ? DRAIN :
                  state_q == DRAIN && !s1_v_q && !s2_v_q ? READY : state_q;
        cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
        s1_v_d = accept;
        s1_addr_d = ir.ir_addr;
        s1_val_d = ir.ir_val;
        s1_rd_d = rword;
        s2_v_d = s1_v_q;
        s2_addr_d = s1_addr_q;
        s2_val_d = s1_val_q;
        s2_old_d = s2_v_q && s2_addr_q == s1_addr_q ? sum : s1_rd_q;
        overflow_d = start ? 1'b0 : overflow_q | (s2_v_q && |carry);
        rd_data_d = state_q == READY ? rword : rd_data_q;
        ir.ir_enable = state_q == ACCUM;
        frame_ready = state_q == READY;
        overflow = overflow_q;
        rd_data = rd_data_q;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            s1_v_q <= 1'b0;
            s1_addr_q <= '0;
            s1_val_q <= '0;
            s1_rd_q <= '0;
            s2_v_q <= 1'b0;
            s2_addr_q <= '0;
            s2_val_q <= '0;
            s2_old_q <= '0;
            overflow_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            s1_v_q <= s1_v_d;
            s1_addr_q <= s1_addr_d;
            s1_val_q <= s1_val_d;
            s1_rd_q <= s1_rd_d;
            s2_v_q <= s2_v_d;
            s2_addr_q <= s2_addr_d;
            s2_val_q <= s2_val_d;
            s2_old_q <= s2_old_d;
            overflow_q <= overflow_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: doc/nabp_image_accumulator.md
Name: nabp_image_accumulator

Overview:
- Image-side stage directly downstream of the NABP core.
- Consumes the packed pixel stream (ir_kick / ir_wr_en / ir_addr / ir_val / ir_done) and accumulates each lane into an on-chip image memory via a read-modify-write pipeline.
- Throttles the core through ir_enable.
- After ir_done, drains the pipeline and exposes the finished image through a host read port.

Parameters:
- DATA_W, 8, width of one pixel lane in ir_val
- LANES, 4, pixels packed per ir_val word (kCacheDataLength = LANES*DATA_W)
- ADDR_W, 10, image word address width (kImageAddressLength); depth = 2^ADDR_W
- ACC_W, 16, accumulator width per lane; memory word = LANES*ACC_W

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-high
- ir_kick  in  1  one-cycle pulse: start new frame
- ir_wr_en  in  1  ir_addr/ir_val valid this cycle
- ir_addr  in  ADDR_W  image word address
- ir_val  in  LANES*DATA_W  packed unsigned pixel contributions, lane 0 in LSBs
- ir_done  in  1  one-cycle pulse: last contribution sent (may coincide with ir_wr_en)
- ir_enable  out  1  ready; core may assert ir_wr_en only while high
- frame_ready  out  1  image complete and readable
- overflow  out  1  sticky; a lane saturated/wrapped this frame
- rd_addr  in  ADDR_W  host read address
- rd_data  out  LANES*ACC_W  host read data, 1-cycle latency

Behaviour:
- Reset (reset_n asserted, async):
  - State = IDLE.
  - ir_enable=0, frame_ready=0, overflow=0, rd_data=0.
  - Pipeline valid bits cleared. Memory contents not reset.
- FSM:
  - IDLE: ir_kick -> CLEAR.
  - CLEAR: counter 0..2^ADDR_W-1 writes zero, one word per cycle; ir_enable=0; after the last word -> ACCUM.
  - ACCUM: ir_enable=1. Each cycle with ir_wr_en=1 is one accepted beat. ir_done -> DRAIN; ir_enable drops the following cycle.
  - DRAIN: ir_enable=0; wait until both pipeline stages are empty (≤2 cycles) -> READY.
  - READY: frame_ready=1; ir_kick -> CLEAR (clears frame_ready, overflow).
- Pipeline:
  - S1: register addr/val, issue memory read.
  - S2: per-lane add of zero-extended DATA_W value to ACC_W word; write back.
  - Throughput 1 beat/cycle; write visible 2 cycles after acceptance.
- Hazards:
  - Same address in consecutive beats: S1 takes S2's sum (forward), not the stale memory word.
  - Same address two beats apart: write-first memory behaviour or an equivalent bypass. Accumulation must be exact for any address sequence.
- Input rules:
  - ir_wr_en while ir_enable=0: ignored.
  - ir_wr_en together with ir_done: beat accepted.
  - ir_kick outside IDLE/READY: ignored.
  - ir_done outside ACCUM: ignored.
- Host read port:
  - rd_data = mem[rd_addr] registered, 1-cycle latency.
  - Valid only while frame_ready=1; otherwise rd_data holds its last value.
  - Port is shared with S1, arbitrated by state.
- Reset mid-operation: immediate return to IDLE; in-flight beats lost; no partial frame_ready.

Optional Feature:
- NABP_ACC_SATURATE_EN
  - Defined: per-lane sum clamps at 2^ACC_W-1; overflow set on any clamp.
  - Undefined: sums wrap modulo 2^ACC_W; overflow set on any carry-out.
  - The overflow port exists in both builds.

Decomposition:
- Shared package/defines: DATA_W, LANES, ADDR_W, ACC_W mapped from kDataLength, kCacheDataLength, kImageAddressLength; FSM state encoding (IDLE, CLEAR, ACCUM, DRAIN, READY).
- One natural sub-module, nabp_lane_adder: a single-lane add with saturate/wrap and carry flag, instantiated LANES times.
- Memory is a simple dual-port inferred array inside the top.

Test Plan:
- Reset, ir_kick, wait 2^ADDR_W cycles -> ir_enable rises; finish with ir_done -> frame_ready=1 and every rd_data=0.
- Addr 5 then addr 9, ir_val=0x04030201 each, then ir_done -> addr 5 reads lanes 1,2,3,4; addr 9 reads lanes 1,2,3,4.
- Hazard: addr 7 on three consecutive cycles, ir_val=0x01010101 -> addr 7 reads lanes 3,3,3,3; repeat with addr 7,8,7 -> addr 7 reads 2 per lane, addr 8 reads 1 per lane.
- Overflow: ACC_W=8, 2 beats of 0xFF lanes to addr 0 -> with NABP_ACC_SATURATE_EN lanes read 0xFF and overflow=1; without it lanes read 0xFE and overflow=1.
- Backpressure/edge: ir_wr_en during CLEAR or DRAIN -> no memory change; ir_done coincident with the final beat -> that beat is included.
- Reset asserted mid-ACCUM -> next cycle ir_enable=0, frame_ready=0, overflow=0; a new ir_kick performs a full clear.
